xs3_to_bin_seq: RTL

Multi-digit Excess-3 to binary sequencer for the code-converter group. It accepts a packed word of NDIG XS-3 digits and walks them MSD-first through a single-digit XS-3 decoder, one digit per clock. Each step accumulates `acc = acc*10 + digit`. The result is a plain binary integer with a done/error handshake. It sits between a parallel XS-3 source (keypad or display bus) and binary arithmetic logic, so one digit decoder is reused across all digit positions.

---
 rtl/xs3_pkg.sv | 25 ++
 rtl/xs3_digit_dec.sv | 15 +
 rtl/xs3_to_bin_seq.sv | 103 ++++++++++
 3 files changed

// File: rtl/xs3_pkg.sv
// Shared types, constants and helpers for the XS-3 to binary sequencer.
package xs3_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] XS3_MIN = 4'b0011;
  localparam logic [3:0] XS3_MAX = 4'b1100;

  function automatic logic xs3_valid(input logic [3:0] code);
    return (code >= XS3_MIN) && (code <= XS3_MAX);
  endfunction

  // Elaboration-time helper for sizing checks
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/xs3_digit_dec.sv
// Single-digit Excess-3 to BCD decoder with code validity flag.
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] xs,
  output logic [3:0] bcd,
  output logic       valid
);

  always_comb begin
    valid = xs3_valid(xs);
    bcd   = valid ? (xs - XS3_MIN) : 4'd0;
  end

endmodule

// File: rtl/xs3_to_bin_seq.sv
// Multi-digit Excess-3 to binary converter: walks digits MSD-first through one
// shared decoder, accumulating acc*10 + d each cycle, with done/err handshake.
module xs3_to_bin_seq
  import xs3_pkg::*;
#(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned BIN_W = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*NDIG-1:0]   xs_in,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [BIN_W-1:0]    bin_out
);

  localparam int unsigned IDX_W    = $clog2(NDIG) + 1;
  localparam bit          WIDTH_OK = (BIN_W >= 64) ||
                                     ((64'd1 << BIN_W) > (pow10(NDIG) - 64'd1));

  if (NDIG < 1) begin : g_bad_ndig
    $error("xs3_to_bin_seq: NDIG must be at least 1");
  end
  if (!WIDTH_OK) begin : g_bad_width
    $error("xs3_to_bin_seq: BIN_W too narrow for 10^NDIG-1");
  end

  state_t             state;
  logic [4*NDIG-1:0]  sr;
  logic [BIN_W-1:0]   acc;
  logic [IDX_W-1:0]   idx;
  logic               err_next;

  logic [3:0]         dig;
  logic               dig_valid;
  logic [BIN_W+3:0]   wide;
  logic [BIN_W-1:0]   acc_next;

  xs3_digit_dec u_dec (
    .xs    (sr[4*NDIG-1 -: 4]),
    .bcd   (dig),
    .valid (dig_valid)
  );

  // acc*10 as two shifts in a 4-bit-wider sum; sizing check makes truncation lossless
  always_comb begin
    wide     = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1) + (BIN_W+4)'(dig);
    acc_next = wide[BIN_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      acc      <= '0;
      idx      <= '0;
      err_next <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      bin_out  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr       <= xs_in;
            acc      <= '0;
            idx      <= '0;
            err_next <= 1'b0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          if (dig_valid) begin
            acc <= acc_next;
            sr  <= sr << 4;
            idx <= idx + 1'b1;
            if (idx == IDX_W'(NDIG - 1)) begin
              err_next <= 1'b0;
              state    <= DONE;
            end
          end else begin
            err_next <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b1;
          bin_out <= err_next ? '0 : acc;
          err     <= err_next;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
